// File: rtl/codificador_pkg.sv
// codificador_pkg: shared constants and the command encoding function for
// the instruction encoder.
//   OP_CARGA_A / OP_CARGA_B : instruction words for "load A" / "load B"
//   SEL_*                   : values of the 2-bit register-select field
//   codifica(sel, ula)      : returns {ilegal, word[3:0]}
package codificador_pkg;

    localparam logic [3:0] OP_CARGA_A = 4'b0000;
    localparam logic [3:0] OP_CARGA_B = 4'b0001;

    localparam logic [1:0] SEL_A      = 2'b10;
    localparam logic [1:0] SEL_B      = 2'b01;
    localparam logic [1:0] SEL_ULA    = 2'b00;
    localparam logic [1:0] SEL_ILEGAL = 2'b11;

    // ALU codes 0000 and 0001 would collide with the load words, so an ALU
    // command carrying them is rejected as illegal.
    function automatic logic [4:0] codifica(input logic [1:0] sel,
                                            input logic [3:0] ula);
        logic [4:0] res;
        res = {1'b1, 4'b0000};
        case (sel)
            SEL_A:   res = {1'b0, OP_CARGA_A};
            SEL_B:   res = {1'b0, OP_CARGA_B};
            SEL_ULA: begin
                if (ula >= 4'b0010) res = {1'b0, ula};
                else                res = {1'b1, 4'b0000};
            end
            default: res = {1'b1, 4'b0000};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/codificador_instrucao_fila.sv
// fila_instrucao: PROF x W synchronous FIFO.
//   push/din   : write din when not full
//   pop/dout   : dout is the head entry; pop removes it when not empty
//   full/empty : occupancy flags derived from nivel
//   nivel      : occupancy 0..PROF
// PROF must be a power of 2 so the pointers wrap by natural overflow.
module fila_instrucao #(
    parameter int PROF = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(PROF):0]   nivel
);

    localparam int AW = $clog2(PROF);

    logic [W-1:0]  mem [PROF];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (nivel == (AW+1)'(PROF));
    assign empty   = (nivel == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            nivel  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   nivel <= nivel + (AW+1)'(1);
                2'b01:   nivel <= nivel - (AW+1)'(1);
                default: nivel <= nivel;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through rd_ptr/nivel.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/codificador_instrucao.sv
// codificador_instrucao: encodes register-select / ALU-op commands into the
// 4-bit decoder instruction word, buffers them and issues them downstream.
//   cmd_valid/cmd_ready     : command handshake in
//   cmd_reg_a_b, cmd_ula    : command fields
//   saida/saida_valid/ready : encoded word handshake out
//   nivel                   : FIFO occupancy 0..PROF
//   erro                    : sticky flag, an illegal command was accepted
// Optional feature macro: CODIFICADOR_BYPASS_EN (empty-FIFO combinational
// bypass from cmd_* to saida*). Default build has no such path.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds data stable while valid && !ready. cmd_ready depends
// only on registered occupancy, never on saida_ready.
module codificador_instrucao
    import codificador_pkg::*;
#(
    parameter int PROF = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_reg_a_b,
    input  logic [3:0]              cmd_ula,
    output logic [3:0]              saida,
    output logic                    saida_valid,
    input  logic                    saida_ready,
    output logic [$clog2(PROF):0]   nivel,
    output logic                    erro
);

    logic       full;
    logic       empty;
    logic [3:0] cabeca;
    logic [4:0] cod;
    logic       ilegal;
    logic [3:0] palavra;
    logic       aceita;
    logic       bypass;
    logic       push;
    logic       pop;

    assign cod     = codifica(cmd_reg_a_b, cmd_ula);
    assign ilegal  = cod[4];
    assign palavra = cod[3:0];

    assign cmd_ready = !full;
    assign aceita    = cmd_valid && cmd_ready;

`ifdef CODIFICADOR_BYPASS_EN
    // Word goes straight out when nothing is queued ahead of it and the
    // consumer takes it this cycle; it is then never written to the FIFO.
    assign bypass = aceita && !ilegal && empty && saida_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = aceita && !ilegal && !bypass;
    assign pop  = !empty && saida_ready;

    assign saida_valid = !empty || bypass;
    // Forced to zero when idle so saida reads 0000 out of reset.
    assign saida = bypass ? palavra : (empty ? 4'b0000 : cabeca);

    fila_instrucao #(
        .PROF (PROF),
        .W    (4)
    ) u_fila (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (palavra),
        .dout  (cabeca),
        .full  (full),
        .empty (empty),
        .nivel (nivel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                erro <= 1'b0;
        else if (aceita && ilegal) erro <= 1'b1;
    end

endmodule

// File: tb/tb_codificador_instrucao.sv
module tb_codificador_instrucao;

    localparam int PROF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_reg_a_b;
    logic [3:0] cmd_ula;
    logic [3:0] saida;
    logic       saida_valid;
    logic       saida_ready;
    logic [2:0] nivel;
    logic       erro;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [3:0] exp_q[$];
    logic       exp_erro;

    codificador_instrucao #(.PROF(PROF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_reg_a_b (cmd_reg_a_b),
        .cmd_ula     (cmd_ula),
        .saida       (saida),
        .saida_valid (saida_valid),
        .saida_ready (saida_ready),
        .nivel       (nivel),
        .erro        (erro)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Encoding rules straight from the command definition.
    task automatic ref_encode(input logic [1:0] sel, input logic [3:0] ula,
                              output logic legal, output logic [3:0] w);
        legal = 1'b1;
        w     = 4'd0;
        if (sel == 2'b10)      w = 4'd0;
        else if (sel == 2'b01) w = 4'd1;
        else if (sel == 2'b00 && ula > 4'd1) w = ula;
        else legal = 1'b0;
    endtask

    task automatic check_outputs(input logic e_ready, input logic e_valid,
                                 input logic [3:0] e_saida, input int e_nivel, input logic e_erro);
        check("cmd_ready",   {7'd0, cmd_ready},   {7'd0, e_ready});
        check("saida_valid", {7'd0, saida_valid}, {7'd0, e_valid});
        check("saida",       {4'd0, saida},       {4'd0, e_saida});
        check("nivel",       {5'd0, nivel},       8'(e_nivel));
        check("erro",        {7'd0, erro},        {7'd0, e_erro});
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks outputs
    // mid-low-phase, then advances the model at the posedge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [3:0] u, input logic r);
        logic       legal;
        logic [3:0] w;
        logic       e_ready;
        logic       acc;
        logic       byp;
        logic [3:0] e_saida;
        cmd_valid   = v;
        cmd_reg_a_b = s;
        cmd_ula     = u;
        saida_ready = r;
        ref_encode(s, u, legal, w);
        e_ready = exp_q.size() < PROF;
        acc     = v && e_ready;
        byp     = 1'b0;
`ifdef CODIFICADOR_BYPASS_EN
        byp = acc && legal && r && (exp_q.size() == 0);
`endif
        e_saida = byp ? w : ((exp_q.size() != 0) ? exp_q[0] : 4'd0);
        #1;
        check_outputs(e_ready, (exp_q.size() != 0) || byp, e_saida, exp_q.size(), exp_erro);
        @(posedge clk);
        if (r && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc && legal && !byp) exp_q.push_back(w);
        if (acc && !legal) exp_erro = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, 2'b00, 4'd0, r);
    endtask

    task automatic do_reset();
        cmd_valid   = 1'b0;
        saida_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        exp_q.delete();
        exp_erro = 1'b0;
        check_outputs(1'b1, 1'b0, 4'd0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_reg_a_b = 2'b00;
        cmd_ula     = 4'd0;
        saida_ready = 1'b0;
        exp_erro    = 1'b0;
        @(negedge clk);
        do_reset();

        // reset release, idle
        idle(1'b0);
        idle(1'b1);

        // load A, load B, ALU 0110 with consumer ready
        cycle(1'b1, 2'b10, 4'hF, 1'b1);
        cycle(1'b1, 2'b01, 4'hA, 1'b1);
        cycle(1'b1, 2'b00, 4'h6, 1'b1);
        repeat (3) idle(1'b1);

        // fill with consumer stalled, fifth held; full refuses even with a pop
        for (int i = 0; i < PROF; i++) cycle(1'b1, 2'b00, 4'(4'h2 + i), 1'b0);
        cycle(1'b1, 2'b00, 4'hE, 1'b0);
        cycle(1'b1, 2'b00, 4'hE, 1'b1);
        cycle(1'b1, 2'b00, 4'hE, 1'b0);
        repeat (PROF + 2) idle(1'b1);

        // illegal commands, then legal traffic keeps erro set
        cycle(1'b1, 2'b11, 4'h7, 1'b1);
        cycle(1'b1, 2'b00, 4'h1, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 1'b1);
        cycle(1'b1, 2'b01, 4'h0, 1'b1);
        repeat (2) idle(1'b1);

        // level 2, then simultaneous push/pop, then reset mid-stream
        cycle(1'b1, 2'b00, 4'h3, 1'b0);
        cycle(1'b1, 2'b00, 4'h4, 1'b0);
        cycle(1'b1, 2'b00, 4'h5, 1'b1);
        cycle(1'b1, 2'b00, 4'h9, 1'b1);
        cycle(1'b1, 2'b10, 4'h0, 1'b0);
        do_reset();
        repeat (2) idle(1'b1);

        // empty FIFO, consumer ready, ALU 1010
        cycle(1'b1, 2'b00, 4'hA, 1'b1);
        repeat (2) idle(1'b1);

        // randomized traffic with varying backpressure and occasional reset
        for (int n = 0; n < 800; n++) begin
            logic v;
            logic r;
            v = ($urandom_range(0, 3) != 0);
            if (n < 400) r = ($urandom_range(0, 3) == 0);
            else         r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // hard time bound in case a task ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "timeout");
    end

endmodule
